// File: rtl/fm_stream_tx.sv
// rtl/fm_stream_tx.sv - paced raster reader streaming feature-map pixels to a window generator
// Reads pixels row-major from the buffer, one every gap+1 cycles, and re-registers them downstream.
module fm_stream_tx #(
  parameter int FM_DEPTH = 64,
  parameter int FM_WIDTH = 56,
  parameter int ADDR_W   = 12
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     mode_in,
  input  logic [3:0]               gap,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [FM_DEPTH*16-1:0]   mem_rd_data,
  output logic                     verticle_sync,
  output logic                     mode_out,
  output logic                     data_out_valid,
  output logic [FM_DEPTH*16-1:0]   data_out,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FM_WIDTH * FM_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [3:0]        gap_q;
  logic [3:0]        pace;
  logic [ADDR_W-1:0] addr;
  logic              rd_pend;

  assign mem_rd_addr = addr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    verticle_sync = 1'b0;
    busy          = 1'b0;
    mem_rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SYNC;
      end
      SYNC: begin
        verticle_sync = 1'b1;
        busy          = 1'b1;
        state_nxt     = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        mem_rd_en = (pace == 4'd0);
        if (mem_rd_en && addr == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave once the final pixel is on data_out and nothing is still in flight.
        if (data_out_valid && !rd_pend) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_out       <= 1'b0;
      gap_q          <= 4'd0;
      pace           <= 4'd0;
      addr           <= '0;
      rd_pend        <= 1'b0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      done           <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_out <= mode_in;
        gap_q    <= gap;
      end
      if (state == SYNC) begin
        addr <= '0;
        pace <= 4'd0;
      end else if (state == RUN) begin
        if (mem_rd_en) begin
          addr <= addr + ADDR_W'(1);
          pace <= gap_q;
        end else begin
          pace <= pace - 4'd1;
        end
      end
      // Two-stage pipe: buffer returns data the cycle after the strobe, then it is registered out.
      rd_pend        <= mem_rd_en;
      data_out_valid <= rd_pend;
      if (rd_pend) data_out <= mem_rd_data;
      done <= (state == DRAIN) && (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_fm_stream_tx.sv
// tb/tb_fm_stream_tx.sv - self-checking bench for fm_stream_tx
// Small 4x4x2 instance for directed/random frames plus a default-size instance for the full frame.
module tb_fm_stream_tx;

  localparam int N  = 16;
  localparam int N2 = 56 * 56;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0, mode_in = 1'b0;
  logic [3:0]  gap = 4'd0;
  logic        mem_rd_en, verticle_sync, mode_out, data_out_valid, busy, done;
  logic [3:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] data_out;

  logic          start2 = 1'b0;
  logic          mem_rd_en2, vs2, mode_out2, valid2, busy2, done2;
  logic [11:0]   addr2;
  logic [1023:0] mem_rd_data2 = '0;
  logic [1023:0] data_out2;

  int checks = 0, errors = 0;
  int cyc = 0;
  int key = 0;
  int c0;
  logic       exp_mode;
  logic [3:0] exp_gap;

  int          vs_q[$], rd_cyc[$], rd_addr[$], v_cyc[$], done_q[$];
  logic [31:0] v_data[$];
  int          busy_cnt, mode_err, hold_err;
  logic [31:0] last_out = '0;

  int rd2_cnt = 0, rd2_last = -1, v2_cnt = 0, done2_cnt = 0, busy2_cnt = 0, data2_err = 0;

  fm_stream_tx #(.FM_DEPTH(2), .FM_WIDTH(4), .ADDR_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode_in(mode_in), .gap(gap),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .verticle_sync(verticle_sync), .mode_out(mode_out), .data_out_valid(data_out_valid),
    .data_out(data_out), .busy(busy), .done(done)
  );

  fm_stream_tx dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .mode_in(1'b1), .gap(4'd0),
    .mem_rd_en(mem_rd_en2), .mem_rd_addr(addr2), .mem_rd_data(mem_rd_data2),
    .verticle_sync(vs2), .mode_out(mode_out2), .data_out_valid(valid2),
    .data_out(data_out2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Channel c of pixel a holds a + c*key.
  function automatic logic [31:0] pix(input int a, input int k);
    logic [31:0] p;
    p[15:0]  = 16'(a);
    p[31:16] = 16'(a + k);
    return p;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en)  mem_rd_data  <= pix(int'(mem_rd_addr), key);
    if (mem_rd_en2) mem_rd_data2 <= {64{{4'b0, addr2}}};
  end

  always @(negedge clk) begin
    if (!rstn) begin
      last_out = '0;
    end else begin
      if (verticle_sync) vs_q.push_back(cyc);
      if (mem_rd_en) begin rd_cyc.push_back(cyc); rd_addr.push_back(int'(mem_rd_addr)); end
      if (data_out_valid) begin
        v_cyc.push_back(cyc); v_data.push_back(data_out); last_out = data_out;
      end else if (data_out !== last_out) hold_err++;
      if (done) done_q.push_back(cyc);
      if (busy) begin
        busy_cnt++;
        if (mode_out !== exp_mode) mode_err++;
      end
      if (mem_rd_en2) begin rd2_cnt++; rd2_last = int'(addr2); end
      if (valid2) begin
        if (data_out2 !== {64{16'(v2_cnt)}}) data2_err++;
        v2_cnt++;
      end
      if (done2) done2_cnt++;
      if (busy2) busy2_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    vs_q.delete(); rd_cyc.delete(); rd_addr.delete(); v_cyc.delete(); v_data.delete(); done_q.delete();
    busy_cnt = 0; mode_err = 0; hold_err = 0;
  endtask

  task automatic begin_frame(input logic m, input logic [3:0] g, input int k);
    @(negedge clk); #1;
    key = k; mode_in = m; gap = g; start = 1'b1;
    clear_frame();
    c0 = cyc; exp_mode = m; exp_gap = g;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_timeout", 64'(done_q.size() > 0), 64'd1);
  endtask

  // Expected frame timeline derived from the start-sample cycle c0 and the latched gap.
  task automatic check_frame(input string name);
    int p, nr, nv;
    p = int'(exp_gap) + 1;
    chk({name, ":vs_count"}, 64'(vs_q.size()), 64'd1);
    if (vs_q.size() > 0) chk({name, ":vs_cycle"}, 64'(vs_q[0]), 64'(c0 + 1));
    chk({name, ":rd_count"}, 64'(rd_cyc.size()), 64'(N));
    chk({name, ":valid_count"}, 64'(v_cyc.size()), 64'(N));
    nr = (rd_cyc.size() < N) ? rd_cyc.size() : N;
    nv = (v_cyc.size() < N) ? v_cyc.size() : N;
    for (int k = 0; k < nr; k++) begin
      chk({name, ":rd_cycle"}, 64'(rd_cyc[k]), 64'(c0 + 2 + k * p));
      chk({name, ":rd_addr"}, 64'(rd_addr[k]), 64'(k));
    end
    for (int k = 0; k < nv; k++) begin
      chk({name, ":valid_cycle"}, 64'(v_cyc[k]), 64'(c0 + 4 + k * p));
      chk({name, ":data_out"}, 64'(v_data[k]), 64'(pix(k, key)));
    end
    chk({name, ":done_count"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) chk({name, ":done_cycle"}, 64'(done_q[0]), 64'(c0 + 5 + (N - 1) * p));
    chk({name, ":busy_cycles"}, 64'(busy_cnt), 64'((N - 1) * p + 4));
    chk({name, ":mode_out_stable"}, 64'(mode_err), 64'd0);
    chk({name, ":data_hold"}, 64'(hold_err), 64'd0);
  endtask

  initial begin
    exp_mode = 1'b0; exp_gap = 4'd0; c0 = 0;
    clear_frame();
    repeat (3) @(negedge clk);
    #1;
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:vs", 64'(verticle_sync), 64'd0);
    chk("rst:rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst:addr", 64'(mem_rd_addr), 64'd0);
    chk("rst:data_out", 64'(data_out), 64'd0);
    chk("rst:mode_out", 64'(mode_out), 64'd0);
    chk("rst:done", 64'(done), 64'd0);
    rstn = 1'b1;

    begin_frame(1'b1, 4'd0, 0);
    wait_done(400);
    check_frame("gap0");
    if (v_data.size() == N) chk("gap0:last_pixel", 64'(v_data[N-1]), 64'h000F000F);

    begin_frame(1'($urandom), 4'd7, int'($urandom_range(0, 65535)));
    wait_done(400);
    check_frame("gap7");

    begin_frame(1'b0, 4'd3, int'($urandom_range(0, 65535)));
    repeat (20) @(negedge clk);
    #1;
    mode_in = 1'b1; gap = 4'd0; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(400);
    check_frame("midchange");

    @(negedge clk); #1;
    key = int'($urandom_range(0, 65535)); mode_in = 1'b1; gap = 4'd1; start = 1'b1;
    clear_frame();
    c0 = cyc; exp_mode = 1'b1; exp_gap = 4'd1;
    repeat (10) @(negedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #1 start = 1'b1;
    wait_done(400);
    check_frame("held_start");
    c0 = cyc; mode_in = 1'b0; exp_mode = 1'b0;
    clear_frame();
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
    check_frame("done_restart");

    for (int i = 0; i < 4; i++) begin
      begin_frame(1'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
      wait_done(400);
      check_frame("random");
    end

    begin_frame(1'b1, 4'd2, int'($urandom_range(0, 65535)));
    for (int n = 0; n < 400 && v_cyc.size() < 5; n++) begin
      @(negedge clk); #1;
    end
    chk("rst_mid:reached_5", 64'(v_cyc.size()), 64'd5);
    rstn = 1'b0;
    #1;
    chk("rst_mid:busy", 64'(busy), 64'd0);
    chk("rst_mid:rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_mid:addr", 64'(mem_rd_addr), 64'd0);
    chk("rst_mid:valid", 64'(data_out_valid), 64'd0);
    chk("rst_mid:data_out", 64'(data_out), 64'd0);
    chk("rst_mid:mode_out", 64'(mode_out), 64'd0);
    chk("rst_mid:done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    clear_frame();
    repeat (12) @(negedge clk);
    #1;
    chk("post_rst:quiet", 64'(vs_q.size() + rd_cyc.size() + v_cyc.size() + done_q.size() + busy_cnt), 64'd0);

    begin_frame(1'b0, 4'd0, int'($urandom_range(0, 65535)));
    wait_done(400);
    check_frame("fresh");

    @(negedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int n = 0; n < 4000 && done2_cnt == 0; n++) begin
      @(negedge clk); #1;
    end
    chk("full:rd_count", 64'(rd2_cnt), 64'(N2));
    chk("full:last_addr", 64'(rd2_last), 64'(N2 - 1));
    chk("full:valid_count", 64'(v2_cnt), 64'(N2));
    chk("full:data", 64'(data2_err), 64'd0);
    chk("full:done_count", 64'(done2_cnt), 64'd1);
    chk("full:busy_cycles", 64'(busy2_cnt), 64'(N2 + 3));
    chk("full:mode_out", 64'(mode_out2), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
